// File: rtl/esp32_link_sequencer_if.sv
// Gamepad frame stream from the SPI receiver into the ESP32 link sequencer.
// frame_valid is a one-cycle pulse with no back-pressure (the sequencer is always ready); pad_btn_in is meaningful only while frame_valid is high.
interface esp32_link_sequencer_if;
    logic        frame_valid;
    logic [11:0] pad_btn_in;

    modport master (
        output frame_valid,
        output pad_btn_in
    );

    modport slave (
        input frame_valid,
        input pad_btn_in
    );
endinterface

// File: rtl/esp32_link_sequencer.sv
// Drives the ESP32 EN/strap pins through timed resets, watches the SPI frame
// stream for liveness, and gates gamepad buttons while the link is down.
module esp32_link_sequencer #(
    parameter int unsigned RESET_CYCLES  = 1000,
    parameter int unsigned STRAP_CYCLES  = 500,
    parameter int unsigned BOOT_TIMEOUT  = 2000000,
    parameter int unsigned FRAME_TIMEOUT = 500000,
    parameter int unsigned MAX_RETRIES   = 7
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         user_reset,
    input  logic                         prog_mode,
    esp32_link_sequencer_if.slave        pad_rx,
    output logic                         esp32_en,
    output logic                         esp32_gpio0,
    output logic                         esp32_gpio12,
    output logic                         link_up,
    output logic [3:0]                   retry_count,
    output logic [2:0]                   seq_state,
    output logic [11:0]                  pad_btn
);

    localparam logic [2:0] S_RESET  = 3'd0;
    localparam logic [2:0] S_STRAP  = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_LINKED = 3'd3;
    localparam logic [2:0] S_PROG   = 3'd4;
    localparam logic [2:0] S_FAILED = 3'd5;

    localparam logic [23:0] RESET_LAST = 24'(RESET_CYCLES - 1);
    localparam logic [23:0] STRAP_LAST = 24'(STRAP_CYCLES - 1);
    localparam logic [23:0] BOOT_LAST  = 24'(BOOT_TIMEOUT - 1);
    localparam logic [23:0] FRAME_LAST = 24'(FRAME_TIMEOUT - 1);
    localparam logic [3:0]  RETRY_MAX  = 4'(MAX_RETRIES);

    logic [2:0]  state_q, state_d;
    logic [23:0] cnt_q, cnt_d;
    logic [3:0]  retry_q, retry_d;
    logic [11:0] pad_q, pad_d;
    logic        prog_q, prog_d;
    logic        first_q;
    logic        ur_prev_q;
    logic        en_q, en_d;
    logic        gpio0_q, gpio0_d;
    logic        link_q, link_d;

    logic        ur_edge;
    logic [3:0]  retry_inc;

    always_comb begin
        ur_edge   = user_reset & ~ur_prev_q;
        retry_inc = (retry_q == 4'hF) ? 4'hF : retry_q + 4'd1;

        state_d = state_q;
        cnt_d   = cnt_q + 24'd1;
        retry_d = retry_q;
        pad_d   = 12'd0;
        prog_d  = prog_q;

        case (state_q)
            S_RESET: begin
                if (user_reset) begin
                    cnt_d = 24'd0;
                end else if (cnt_q == RESET_LAST) begin
                    state_d = S_STRAP;
                    cnt_d   = 24'd0;
                end
            end
            S_STRAP: begin
                if (cnt_q == STRAP_LAST) begin
                    state_d = prog_q ? S_PROG : S_WAIT;
                    cnt_d   = 24'd0;
                end
            end
            S_WAIT: begin
                // A frame arriving on the timeout cycle still counts as a link.
                if (pad_rx.frame_valid) begin
                    state_d = S_LINKED;
                    cnt_d   = 24'd0;
                    retry_d = 4'd0;
                    pad_d   = pad_rx.pad_btn_in;
                end else if (cnt_q == BOOT_LAST) begin
                    retry_d = retry_inc;
                    cnt_d   = 24'd0;
                    state_d = (retry_inc >= RETRY_MAX) ? S_FAILED : S_RESET;
                end
            end
            S_LINKED: begin
                pad_d = pad_q;
                if (pad_rx.frame_valid) begin
                    pad_d = pad_rx.pad_btn_in;
                    cnt_d = 24'd0;
                end else if (cnt_q == FRAME_LAST) begin
                    state_d = S_RESET;
                    cnt_d   = 24'd0;
                    retry_d = retry_inc;
                    pad_d   = 12'd0;
                end
            end
            S_PROG, S_FAILED: begin
                cnt_d = 24'd0;
            end
            default: begin
                state_d = S_RESET;
                cnt_d   = 24'd0;
            end
        endcase

        if (ur_edge) begin
            state_d = S_RESET;
            cnt_d   = 24'd0;
            retry_d = 4'd0;
            pad_d   = 12'd0;
        end

        // Coming out of reset counts as an entry into S_RESET for the strap latch.
        if (first_q || (state_d == S_RESET && (state_q != S_RESET || ur_edge))) begin
            prog_d = prog_mode;
        end

        en_d    = (state_d != S_RESET);
        gpio0_d = (state_d == S_RESET || state_d == S_STRAP) ? ~prog_d : 1'b1;
        link_d  = (state_d == S_LINKED);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_RESET;
            cnt_q     <= 24'd0;
            retry_q   <= 4'd0;
            pad_q     <= 12'd0;
            prog_q    <= 1'b0;
            first_q   <= 1'b1;
            ur_prev_q <= 1'b0;
            en_q      <= 1'b0;
            gpio0_q   <= 1'b1;
            link_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retry_q   <= retry_d;
            pad_q     <= pad_d;
            prog_q    <= prog_d;
            first_q   <= 1'b0;
            ur_prev_q <= user_reset;
            en_q      <= en_d;
            gpio0_q   <= gpio0_d;
            link_q    <= link_d;
        end
    end

    assign esp32_en     = en_q;
    assign esp32_gpio0  = gpio0_q;
    assign esp32_gpio12 = 1'b0;
    assign link_up      = link_q;
    assign retry_count  = retry_q;
    assign seq_state    = state_q;
    assign pad_btn      = pad_q;

endmodule

// File: tb/tb_esp32_link_sequencer.sv
// Directed bench for esp32_link_sequencer with small timing parameters:
// RESET=4, STRAP=3, BOOT=10, FRAME=8, MAX_RETRIES=2.
module tb_esp32_link_sequencer;

  logic        clk;
  logic        reset;
  logic        user_reset;
  logic        prog_mode;
  logic        esp32_en;
  logic        esp32_gpio0;
  logic        esp32_gpio12;
  logic        link_up;
  logic [3:0]  retry_count;
  logic [2:0]  seq_state;
  logic [11:0] pad_btn;

  int n_checks;
  int n_bad;

  esp32_link_sequencer_if pad_if ();

  esp32_link_sequencer #(
    .RESET_CYCLES (4),
    .STRAP_CYCLES (3),
    .BOOT_TIMEOUT (10),
    .FRAME_TIMEOUT(8),
    .MAX_RETRIES  (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .user_reset  (user_reset),
    .prog_mode   (prog_mode),
    .pad_rx      (pad_if),
    .esp32_en    (esp32_en),
    .esp32_gpio0 (esp32_gpio0),
    .esp32_gpio12(esp32_gpio12),
    .link_up     (link_up),
    .retry_count (retry_count),
    .seq_state   (seq_state),
    .pad_btn     (pad_btn)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "bench time limit");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_frame(input logic [11:0] val);
    pad_if.frame_valid = 1'b1;
    pad_if.pad_btn_in  = val;
    step(1);
    pad_if.frame_valid = 1'b0;
    pad_if.pad_btn_in  = 12'($urandom_range(1, 4095));
  endtask

  initial begin
    n_checks = 0;
    n_bad    = 0;
    reset = 1'b1;
    user_reset = 1'b0;
    prog_mode = 1'b0;
    pad_if.frame_valid = 1'b0;
    pad_if.pad_btn_in  = 12'h000;
    step(3);

    // reset values while reset is held
    check("rst_state", seq_state, 0);
    check("rst_en", esp32_en, 0);
    check("rst_gpio0", esp32_gpio0, 1);
    check("rst_gpio12", esp32_gpio12, 0);
    check("rst_link", link_up, 0);
    check("rst_retry", retry_count, 0);
    check("rst_pad", pad_btn, 0);

    // 1: bring-up; release at cycle 0 sample point
    reset = 1'b0;
    for (int c = 0; c < 12; c++) begin
      check($sformatf("bu_en_c%0d", c), esp32_en, (c >= 4) ? 1 : 0);
      check($sformatf("bu_gpio0_c%0d", c), esp32_gpio0, 1);
      check($sformatf("bu_link_c%0d", c), link_up, 0);
      if (c == 7) check("bu_wait_state", seq_state, 2);
      step(1);
    end
    check("bu_state_c12", seq_state, 2);
    pulse_frame(12'hA5C);                       // cycle 12 -> now cycle 13
    check("bu_link_c13", link_up, 1);
    check("bu_pad_c13", pad_btn, 12'hA5C);
    check("bu_state_c13", seq_state, 3);
    check("bu_retry_c13", retry_count, 0);

    // 5a: frame exactly on the frame-timeout cycle (cnt=7 at cycle 20)
    step(7);
    check("race_pre_link", link_up, 1);
    check("race_pre_pad", pad_btn, 12'hA5C);
    pulse_frame(12'h3C1);                       // now cycle 21
    check("race_state", seq_state, 3);
    check("race_pad", pad_btn, 12'h3C1);

    // 2: link loss, no frames from cycle 21
    step(7);                                    // cycle 28, cnt=7
    check("loss_c28_link", link_up, 1);
    step(1);                                    // cycle 29
    check("loss_link", link_up, 0);
    check("loss_pad", pad_btn, 0);
    check("loss_en", esp32_en, 0);
    check("loss_retry", retry_count, 1);
    check("loss_state", seq_state, 0);
    for (int i = 0; i < 3; i++) begin
      step(1);
      check($sformatf("loss_en_low%0d", i), esp32_en, 0);
    end
    step(1);                                    // cycle 33
    check("loss_en_high", esp32_en, 1);
    check("loss_strap", seq_state, 1);
    step(3);                                    // cycle 36
    check("loss_wait", seq_state, 2);

    // 5b: user_reset edge together with a frame in S_WAIT
    step(1);                                    // cycle 37
    user_reset = 1'b1;
    pulse_frame(12'hABC);                       // cycle 38
    check("ur_race_state", seq_state, 0);
    check("ur_race_pad", pad_btn, 0);
    check("ur_race_link", link_up, 0);
    check("ur_race_retry", retry_count, 0);
    check("ur_race_en", esp32_en, 0);
    step(4);                                    // cycle 42, still held
    check("ur_hold_state", seq_state, 0);
    check("ur_hold_en", esp32_en, 0);
    user_reset = 1'b0;                          // R = 42

    // 3: give-up with MAX_RETRIES=2
    step(16);
    check("gu_wait1", seq_state, 2);
    step(1);
    check("gu_retry1", retry_count, 1);
    check("gu_reset1", seq_state, 0);
    check("gu_en1", esp32_en, 0);
    step(16);
    check("gu_wait2", seq_state, 2);
    step(1);
    check("gu_failed", seq_state, 5);
    check("gu_retry2", retry_count, 2);
    check("gu_en", esp32_en, 1);
    check("gu_gpio0", esp32_gpio0, 1);
    check("gu_link", link_up, 0);
    pulse_frame(12'h5A5);
    check("gu_frame_state", seq_state, 5);
    check("gu_frame_pad", pad_btn, 0);
    step(100);
    check("gu_hold_state", seq_state, 5);
    check("gu_hold_retry", retry_count, 2);
    check("gu_hold_en", esp32_en, 1);

    // user_reset restart, entering programming mode (test 4)
    user_reset = 1'b1;
    prog_mode = 1'b1;
    step(1);                                    // P
    user_reset = 1'b0;
    check("ur_restart_state", seq_state, 0);
    check("ur_restart_retry", retry_count, 0);
    check("pm_gpio0_p0", esp32_gpio0, 0);
    check("pm_en_p0", esp32_en, 0);
    for (int i = 1; i < 7; i++) begin
      step(1);
      check($sformatf("pm_gpio0_p%0d", i), esp32_gpio0, 0);
      check($sformatf("pm_en_p%0d", i), esp32_en, (i >= 4) ? 1 : 0);
    end
    step(1);                                    // P+7
    prog_mode = 1'b0;
    check("pm_state", seq_state, 4);
    check("pm_gpio0", esp32_gpio0, 1);
    check("pm_en", esp32_en, 1);
    pulse_frame(12'hFFF);
    check("pm_frame_pad", pad_btn, 0);
    check("pm_frame_state", seq_state, 4);
    check("pm_frame_link", link_up, 0);
    step(100);
    check("pm_hold_state", seq_state, 4);
    check("pm_hold_en", esp32_en, 1);

    // 6: async reset between edges in S_STRAP
    user_reset = 1'b1;
    step(1);                                    // Q
    user_reset = 1'b0;
    check("ar_q_state", seq_state, 0);
    check("ar_q_gpio0", esp32_gpio0, 1);
    step(5);                                    // Q+5, S_STRAP
    check("ar_pre_state", seq_state, 1);
    check("ar_pre_en", esp32_en, 1);
    #2;
    reset = 1'b1;
    #1;
    check("ar_state", seq_state, 0);
    check("ar_en", esp32_en, 0);
    check("ar_pad", pad_btn, 0);
    check("ar_gpio0", esp32_gpio0, 1);
    check("ar_link", link_up, 0);
    check("ar_retry", retry_count, 0);

    // power-on with prog_mode high: straps latched from the first edge
    prog_mode = 1'b1;
    step(2);
    reset = 1'b0;
    check("po_gpio0_c0", esp32_gpio0, 1);
    for (int i = 1; i < 7; i++) begin
      step(1);
      check($sformatf("po_gpio0_c%0d", i), esp32_gpio0, 0);
    end
    step(1);
    check("po_state", seq_state, 4);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
